// File: rtl/lsm_calc.sv
// lsm_calc: least-squares line fit over a stream of (x, y) samples.
// It accumulates n, Sx, Sy, Sxx and Sxy while samples arrive. After the last
// sample it computes the slope b1 and then the intercept b0. Both results are
// signed Q16.16 and share one 64-iteration restoring divider.
//
// Sample handshake: a sample is taken on any clock edge where sample_valid=1
// and the block is in ACCUM. There is no back-pressure. sample_last only
// matters when sample_valid=1, and it ends the run. cal_start takes priority
// over a sample presented in the same cycle.
module lsm_calc #(
  parameter int DW    = 16,
  parameter int N_MAX = 64,
  parameter int F     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cal_start,
  input  logic          sample_valid,
  input  logic          sample_last,
  input  logic [DW-1:0] x_in,
  input  logic [DW-1:0] y_in,
  output logic          busy,
  output logic          cal_finish,
  output logic [31:0]   b1,
  output logic [31:0]   b0,
  output logic          err
);

  localparam int NW = $clog2(N_MAX + 1);
  localparam logic [NW-1:0] N_MAX_C = NW'(N_MAX);

  typedef enum logic [2:0] {
    IDLE, ACCUM, PREP, DIV1, PREP2, DIV2, DONE
  } state_t;

  state_t state, state_nx;

  // Accumulators
  logic [NW-1:0]       n;
  logic signed [31:0]  sx, sy;
  logic signed [47:0]  sxx, sxy;
  logic                ovf;
  logic signed [31:0]  b1_int;

  // Divider registers. The divider works on magnitudes, and neg holds the
  // sign of the final result.
  logic [63:0] dvd, dvs, quo, rem;
  logic        neg;
  logic [5:0]  cnt;

  // Sign-extended sample products
  logic signed [31:0] x_e, y_e, xx, xy;
  assign x_e = 32'($signed(x_in));
  assign y_e = 32'($signed(y_in));
  assign xx  = x_e * x_e;
  assign xy  = x_e * y_e;

  // Operands for the two divisions, all 64-bit signed
  logic signed [63:0] n_w, sx_w, sy_w, sxx_w, sxy_w, b1_w;
  logic signed [63:0] num, den, dvd1, dvd2;

  // Form the numerator and denominator of b1, and the dividend of b0
  always_comb begin
    n_w   = 64'(n);
    sx_w  = 64'(sx);
    sy_w  = 64'(sy);
    sxx_w = 64'(sxx);
    sxy_w = 64'(sxy);
    b1_w  = 64'(b1_int);
    num   = n_w * sxy_w - sx_w * sy_w;
    den   = n_w * sxx_w - sx_w * sx_w;
    dvd1  = num <<< F;
    dvd2  = (sy_w <<< F) - b1_w * sx_w;
  end

  function automatic logic [63:0] mag64(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

  // Clamp a signed magnitude to the 32-bit two's complement range
  function automatic logic [31:0] sat32(input logic [63:0] q, input logic ng);
    if (ng) begin
      if (q > 64'h0000_0000_8000_0000) return 32'h8000_0000;
      return ~q[31:0] + 32'd1;
    end
    if (q > 64'h0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    return q[31:0];
  endfunction

  // One restoring-division step: shift in the next dividend bit, then
  // subtract the divisor if it fits
  logic [64:0] rem_sh, diff;
  logic [63:0] rem_nx, quo_nx;
  logic [31:0] q_sat;
  logic        div_last;
  always_comb begin
    rem_sh = {rem, dvd[63]};
    diff   = rem_sh - {1'b0, dvs};
    if (!diff[64]) begin
      rem_nx = diff[63:0];
      quo_nx = {quo[62:0], 1'b1};
    end else begin
      rem_nx = rem_sh[63:0];
      quo_nx = {quo[62:0], 1'b0};
    end
    q_sat    = sat32(quo_nx, neg);
    div_last = (cnt == 6'd63);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic and status outputs
  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    cal_finish = (state == DONE);
    unique case (state)
      IDLE:  if (cal_start) state_nx = ACCUM;
      ACCUM: if (!cal_start && sample_valid && sample_last) state_nx = PREP;
      PREP:  state_nx = ((den == 64'sd0) || ovf) ? DONE : DIV1;
      DIV1:  if (div_last) state_nx = PREP2;
      PREP2: state_nx = DIV2;
      DIV2:  if (div_last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accumulators, divider and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      n      <= '0;
      sx     <= '0;
      sy     <= '0;
      sxx    <= '0;
      sxy    <= '0;
      ovf    <= 1'b0;
      b1_int <= '0;
      dvd    <= '0;
      dvs    <= '0;
      quo    <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      b0     <= '0;
      b1     <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (cal_start) begin
            n   <= '0;
            sx  <= '0;
            sy  <= '0;
            sxx <= '0;
            sxy <= '0;
            ovf <= 1'b0;
          end else if (state == ACCUM && sample_valid) begin
            if (n < N_MAX_C) begin
              n   <= n + NW'(1);
              sx  <= sx + x_e;
              sy  <= sy + y_e;
              sxx <= sxx + 48'(xx);
              sxy <= sxy + 48'(xy);
            end else begin
              ovf <= 1'b1;
            end
          end
        end
        PREP: begin
          if ((den == 64'sd0) || ovf) begin
            err <= 1'b1;
            b0  <= '0;
            b1  <= '0;
          end else begin
            dvd <= mag64(dvd1);
            dvs <= mag64(den);
            neg <= dvd1[63] ^ den[63];
            rem <= '0;
            quo <= '0;
            cnt <= '0;
          end
        end
        PREP2: begin
          dvd <= mag64(dvd2);
          dvs <= mag64(n_w);
          neg <= dvd2[63];
          rem <= '0;
          quo <= '0;
          cnt <= '0;
        end
        DIV1, DIV2: begin
          dvd <= dvd << 1;
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 6'd1;
          if (div_last) begin
            if (state == DIV1) begin
              b1_int <= q_sat;
            end else begin
              b0  <= q_sat;
              b1  <= b1_int;
              err <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_calc.sv
// Directed bench for lsm_calc. Expected results are worked out by hand.
module tb_lsm_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cal_start = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_last = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        busy, cal_finish, err;
  logic [31:0] b1, b0;

  int n_vec = 0;
  int n_err = 0;
  int xs[$];
  int ys[$];
  logic [64:0] exp_q[$];

  lsm_calc #(.DW(16), .N_MAX(64), .F(16)) dut (
    .clk(clk), .rst(rst), .cal_start(cal_start),
    .sample_valid(sample_valid), .sample_last(sample_last),
    .x_in(x_in), .y_in(y_in), .busy(busy), .cal_finish(cal_finish),
    .b1(b1), .b0(b0), .err(err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_samples();
    for (int i = 0; i < xs.size(); i++) begin
      sample_valid = 1'b1;
      x_in = 16'(xs[i]);
      y_in = 16'(ys[i]);
      sample_last = (i == xs.size() - 1);
      tick();
    end
    sample_valid = 1'b0;
    sample_last = 1'b0;
  endtask

  task automatic pulse_start();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
  endtask

  task automatic run_case(input string tag, input int lat_exp, input logic [31:0] b1_e,
                          input logic [31:0] b0_e, input logic err_e, input bit junk);
    int lat;
    logic [64:0] e;
    exp_q.push_back({err_e, b1_e, b0_e});
    pulse_start();
    check({tag, "/busy_start"}, 64'(busy), 64'd1);
    if (junk) begin
      for (int i = 0; i < 2; i++) begin
        sample_valid = 1'b1;
        x_in = 16'd100;
        y_in = 16'hFFFD;
        tick();
      end
      sample_valid = 1'b0;
      pulse_start();
    end
    send_samples();
    lat = 1;
    while (cal_finish !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(lat_exp));
    e = exp_q.pop_front();
    check({tag, "/b1"}, 64'(b1), 64'(e[63:32]));
    check({tag, "/b0"}, 64'(b0), 64'(e[31:0]));
    check({tag, "/err"}, 64'(err), 64'(e[64]));
    check({tag, "/busy_done"}, 64'(busy), 64'd1);
    tick();
    check({tag, "/busy_after"}, 64'(busy), 64'd0);
    check({tag, "/finish_after"}, 64'(cal_finish), 64'd0);
  endtask

  task automatic load_line();
    xs = '{1, 2, 3};
    ys = '{3, 5, 7};
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) tick();
    check("reset/busy", 64'(busy), 64'd0);
    check("reset/finish", 64'(cal_finish), 64'd0);
    check("reset/b1", 64'(b1), 64'd0);
    check("reset/b0", 64'(b0), 64'd0);
    check("reset/err", 64'(err), 64'd0);
    rst = 1'b1;
    tick();

    // y = 2x + 1
    load_line();
    run_case("line", 131, 32'h0002_0000, 32'h0001_0000, 1'b0, 1'b0);

    // Results hold in IDLE, and samples arriving in IDLE are ignored
    repeat (3) tick();
    sample_valid = 1'b1;
    sample_last = 1'b1;
    x_in = 16'd9;
    y_in = 16'd9;
    tick();
    sample_valid = 1'b0;
    sample_last = 1'b0;
    tick();
    check("idle/busy", 64'(busy), 64'd0);
    check("idle/b1_hold", 64'(b1), 64'h0002_0000);
    check("idle/b0_hold", 64'(b0), 64'h0001_0000);

    // Fractional slope, negative intercept truncated toward zero
    xs = '{0, 1, 2};
    ys = '{0, 0, 1};
    run_case("frac", 131, 32'h0000_8000, 32'hFFFF_D556, 1'b0, 1'b0);

    // Flat line
    xs = '{0, 4};
    ys = '{5, 5};
    run_case("flat", 131, 32'h0000_0000, 32'h0005_0000, 1'b0, 1'b0);

    // Single sample gives den == 0
    xs = '{7};
    ys = '{9};
    run_case("degen", 2, 32'h0, 32'h0, 1'b1, 1'b0);

    // 65 samples: the last one overflows
    xs.delete();
    ys.delete();
    for (int i = 0; i < 65; i++) begin
      xs.push_back(i % 8);
      ys.push_back(i);
    end
    run_case("ovf", 2, 32'h0, 32'h0, 1'b1, 1'b0);

    // cal_start in ACCUM discards the samples already taken
    load_line();
    run_case("restart", 131, 32'h0002_0000, 32'h0001_0000, 1'b0, 1'b1);

    // Reset while the first division is running
    pulse_start();
    load_line();
    send_samples();
    repeat (10) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst/busy", 64'(busy), 64'd0);
    check("midrst/finish", 64'(cal_finish), 64'd0);
    check("midrst/b1", 64'(b1), 64'd0);
    check("midrst/b0", 64'(b0), 64'd0);
    check("midrst/err", 64'(err), 64'd0);
    repeat (2) tick();
    load_line();
    run_case("after_rst", 131, 32'h0002_0000, 32'h0001_0000, 1'b0, 1'b0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsm_calc.md
Name: lsm_calc

Overview:
- Calculation stage driven by the line-reader datapath/controller pair.
- The upstream datapath delivers one (x, y) sample per file line.
- The block accumulates least-squares sums over the samples. After the last sample it computes the regression line y = b0 + b1*x with a shared sequential divider, then pulses cal_finish so the controller can write the result line.

Parameters:
- DW, 16: signed width of x_in and y_in.
- N_MAX, 64: maximum samples per run.
- F, 16: fractional bits of the b0/b1 outputs (Q16.16).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- cal_start  input  1  one-cycle pulse. Clears accumulators and begins a run.
- sample_valid  input  1  x_in/y_in carry a sample this cycle.
- sample_last  input  1  qualifies sample_valid; marks the final sample.
- x_in  input  DW  signed sample x.
- y_in  input  DW  signed sample y.
- busy  output  1  high from cal_start until cal_finish inclusive.
- cal_finish  output  1  one-cycle pulse; b0/b1/err valid from this cycle.
- b1  output  32  signed Q16.16 slope.
- b0  output  32  signed Q16.16 intercept.
- err  output  1  degenerate or overflowed run.

Behaviour:
- Reset (rst==0 at clk edge):
  - State goes to IDLE and all accumulators clear.
  - busy=0, cal_finish=0, b0=0, b1=0, err=0.
  - Applies from any state, including mid-division.
- States: IDLE, ACCUM, PREP, DIV1, PREP2, DIV2, DONE.
- IDLE:
  - cal_start -> ACCUM. Clear n, Sx, Sy, Sxx, Sxy and the overflow flag.
  - Samples in IDLE are ignored.
  - b0/b1/err hold their last results.
- ACCUM:
  - Each sample_valid cycle with n<N_MAX: n+=1, Sx+=x, Sy+=y, Sxx+=x*x, Sxy+=x*y, all signed and full width (no loss).
  - sample_valid with n==N_MAX: sample is dropped and the overflow flag is set.
  - sample_valid && sample_last -> PREP. That sample is accumulated when n<N_MAX.
  - cal_start in ACCUM restarts: accumulators clear, stay in ACCUM.
  - cal_start in any later state is ignored.
- PREP (1 cycle):
  - num = n*Sxy - Sx*Sy and den = n*Sxx - Sx*Sx, signed, at least 48 bits.
  - den==0 or overflow -> DONE with err=1, b0=b1=0.
  - Otherwise load divider with dividend = num<<F, divisor = den.
- Divider:
  - Restoring, operates on magnitudes; the sign is applied afterwards.
  - Quotient truncates toward zero.
  - Exactly 64 iterations, one per cycle, in both DIV1 and DIV2.
- DIV1 (64 cycles):
  - Quotient saturates to the 32-bit signed range and is stored as b1_int.
  - Then -> PREP2.
- PREP2 (1 cycle):
  - Dividend = (Sy<<F) - b1_int*Sx (signed, at least 56 bits); divisor = n.
  - Then -> DIV2.
- DIV2 (64 cycles):
  - Quotient saturates to 32-bit signed and becomes b0.
  - b1 register updates together with b0.
  - Then -> DONE.
- DONE (1 cycle): cal_finish=1, busy=1. Next cycle goes to IDLE with busy=0.
- Latency: last-sample edge to cal_finish = 1+64+1+64+1 = 131 cycles on the normal path; 2 cycles on the err path.
- Saturation does not set err.
- n==0 cannot reach PREP, because sample_last requires sample_valid.

Test Plan:
- Exact line y=2x+1:
  - Stimulus: cal_start; samples (1,3),(2,5),(3,7), last on third.
  - Required: cal_finish 131 cycles later with b1=0x00020000, b0=0x00010000, err=0; busy low the following cycle.
- Fractional and negative result:
  - Stimulus: samples (0,0),(1,0),(2,1).
  - Required: b1=0x00008000, b0=0xFFFFD556 (-10922, truncated toward zero), err=0.
- Flat line:
  - Stimulus: samples (0,5),(4,5).
  - Required: b1=0x00000000, b0=0x00050000, err=0.
- Degenerate run:
  - Stimulus: single sample (7,9) with sample_last.
  - Required: den=0, so cal_finish 2 cycles later with err=1, b0=b1=0.
- Overflow:
  - Stimulus: 65 valid samples, last on the 65th.
  - Required: 65th dropped, err=1, b0=b1=0.
- Reset and restart:
  - Stimulus: rst low for 1 cycle during DIV1.
  - Required: next cycle busy=0, cal_finish=0, b0=b1=0, err=0. A following cal_start plus the exact-line samples produces the exact-line results.
